// File: rtl/pump_driver.sv
// pump_driver: hot/cold pump sequencer with minimum on/off dwell and a
// continuous-on limit, all counted in prescaler ticks.
//
// Optional feature macro: PUMP_DRYRUN_EN
//   defined   -> waterlvl_sensor == 2'b00 in any state forces FAULT
//                (left only by rst)
//   undefined -> waterlvl_sensor is ignored and fault is constant 0
//
// Ports:
//   clk                system clock, rising edge
//   rst                synchronous active-high reset
//   pump_control_hot   hot-pump request
//   pump_control_cold  cold-pump request
//   waterlvl_sensor    water level, 2'b00 = dry
//   hot_pump_en        hot pump drive (HOT_ON only)
//   cold_pump_en       cold pump drive (COLD_ON only)
//   pump_busy          HOT_ON, COLD_ON or HOLD_OFF
//   fault              FAULT state
//   timeout_pulse      one cycle at the start of a timeout-forced HOLD_OFF
//   cmd_conflict       registered: both requests were high last cycle
//
// state    | meaning
// IDLE     | pumps off, waiting for a qualified request
// HOT_ON   | hot pump driven
// COLD_ON  | cold pump driven
// HOLD_OFF | forced-off dwell after any on period
// FAULT    | dry-run detected, pumps off until rst
module pump_driver #(
  parameter int unsigned CLK_DIV       = 50000000,
  parameter int unsigned MIN_ON_TICKS  = 10,
  parameter int unsigned MIN_OFF_TICKS = 5,
  parameter int unsigned MAX_ON_TICKS  = 600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pump_control_hot,
  input  logic       pump_control_cold,
  input  logic [1:0] waterlvl_sensor,
  output logic       hot_pump_en,
  output logic       cold_pump_en,
  output logic       pump_busy,
  output logic       fault,
  output logic       timeout_pulse,
  output logic       cmd_conflict
);

  localparam logic [31:0] DIV_LAST = 32'(CLK_DIV - 1);
  localparam logic [15:0] MIN_ON   = 16'(MIN_ON_TICKS);
  localparam logic [15:0] MIN_OFF  = 16'(MIN_OFF_TICKS);
  localparam logic [15:0] MAX_ON   = 16'(MAX_ON_TICKS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HOT_ON   = 3'd1,
    COLD_ON  = 3'd2,
    HOLD_OFF = 3'd3,
    FAULT    = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [31:0] presc;
  logic [15:0] dwell;
  logic        tick;
  logic        req_hot, req_cold;
  logic        dry;
  logic        timeout_hit;

  assign tick     = (presc == DIV_LAST);
  assign req_hot  = pump_control_hot & ~pump_control_cold;
  assign req_cold = pump_control_cold & ~pump_control_hot;

`ifdef PUMP_DRYRUN_EN
  assign dry = (waterlvl_sensor == 2'b00);
`else
  logic unused_waterlvl;
  assign unused_waterlvl = ^waterlvl_sensor;
  assign dry = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      presc         <= '0;
      dwell         <= '0;
      timeout_pulse <= 1'b0;
      cmd_conflict  <= 1'b0;
    end else begin
      state         <= state_next;
      presc         <= tick ? '0 : presc + 32'd1;
      // dwell restarts on every state change and saturates at all-ones
      if (state_next != state)
        dwell <= '0;
      else if (tick && dwell != 16'hFFFF)
        dwell <= dwell + 16'd1;
      timeout_pulse <= timeout_hit;
      cmd_conflict  <= pump_control_hot & pump_control_cold;
    end
  end

  always_comb begin
    state_next   = state;
    timeout_hit  = 1'b0;
    hot_pump_en  = 1'b0;
    cold_pump_en = 1'b0;
    pump_busy    = 1'b0;
    fault        = 1'b0;
    case (state)
      IDLE: begin
        if (dry)           state_next = FAULT;
        else if (req_hot)  state_next = HOT_ON;
        else if (req_cold) state_next = COLD_ON;
      end
      HOT_ON: begin
        hot_pump_en = 1'b1;
        pump_busy   = 1'b1;
        if (dry) state_next = FAULT;
        else if (dwell >= MAX_ON) begin
          state_next  = HOLD_OFF;
          timeout_hit = 1'b1;
        end else if (dwell >= MIN_ON && !req_hot) state_next = HOLD_OFF;
      end
      COLD_ON: begin
        cold_pump_en = 1'b1;
        pump_busy    = 1'b1;
        if (dry) state_next = FAULT;
        else if (dwell >= MAX_ON) begin
          state_next  = HOLD_OFF;
          timeout_hit = 1'b1;
        end else if (dwell >= MIN_ON && !req_cold) state_next = HOLD_OFF;
      end
      HOLD_OFF: begin
        pump_busy = 1'b1;
        if (dry)                   state_next = FAULT;
        else if (dwell >= MIN_OFF) state_next = IDLE;
      end
      FAULT: begin
        fault = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pump_driver.sv
module tb_pump_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       hot, cold;
  logic [1:0] lvl;
  logic       hot_pump_en, cold_pump_en, pump_busy, fault, timeout_pulse, cmd_conflict;
  logic [5:0] obs;
  int         checks = 0;
  int         errors = 0;

  // obs = {hot_en, cold_en, busy, fault, timeout_pulse, cmd_conflict}
  assign obs = {hot_pump_en, cold_pump_en, pump_busy, fault, timeout_pulse, cmd_conflict};

  always #5 clk = ~clk;

  pump_driver #(
    .CLK_DIV(1), .MIN_ON_TICKS(3), .MIN_OFF_TICKS(2), .MAX_ON_TICKS(8)
  ) dut (
    .clk(clk), .rst(rst),
    .pump_control_hot(hot), .pump_control_cold(cold),
    .waterlvl_sensor(lvl),
    .hot_pump_en(hot_pump_en), .cold_pump_en(cold_pump_en),
    .pump_busy(pump_busy), .fault(fault),
    .timeout_pulse(timeout_pulse), .cmd_conflict(cmd_conflict)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; hot = 1'b0; cold = 1'b0; lvl = 2'b11;
    step(); step();
    checks++;
    if (obs !== 6'b000000) begin
      $display("FAIL reset_outputs got %b want %b", obs, 6'b000000); errors++;
    end
    rst = 1'b0;
    step();
    checks++;
    if (obs !== 6'b000000) begin
      $display("FAIL idle_after_reset got %b want %b", obs, 6'b000000); errors++;
    end
  endtask

  task automatic test_hot_pulse();
    hot = 1'b1;
    step();
    hot = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== 6'b101000) begin
        $display("FAIL hot_pulse_on[%0d] got %b want %b", i, obs, 6'b101000); errors++;
      end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== 6'b001000) begin
        $display("FAIL hot_pulse_hold[%0d] got %b want %b", i, obs, 6'b001000); errors++;
      end
      step();
    end
    checks++;
    if (obs !== 6'b000000) begin
      $display("FAIL hot_pulse_idle got %b want %b", obs, 6'b000000); errors++;
    end
  endtask

  task automatic test_changeover();
    int fall = -1;
    int rise = -1;
    int both = 0;
    hot = 1'b1; cold = 1'b0;
    step();
    for (int i = 0; i < 30; i++) begin
      if (hot_pump_en && cold_pump_en) both++;
      if (fall < 0 && !hot_pump_en) fall = i;
      if (rise < 0 && cold_pump_en) begin
        rise = i; cold = 1'b0;
      end
      if (i == 5) begin
        hot = 1'b0; cold = 1'b1;
      end
      step();
    end
    checks++;
    if (both !== 0) begin
      $display("FAIL changeover_overlap got %0d want 0", both); errors++;
    end
    checks++;
    if (fall !== 6) begin
      $display("FAIL changeover_fall_cycle got %0d want 6", fall); errors++;
    end
    checks++;
    if (rise - fall !== 4) begin
      $display("FAIL changeover_gap got %0d want 4", rise - fall); errors++;
    end
    checks++;
    if (obs !== 6'b000000) begin
      $display("FAIL changeover_end got %b want %b", obs, 6'b000000); errors++;
    end
  endtask

  task automatic test_timeout();
    int waited = 0;
    hot = 1'b1; cold = 1'b0;
    step();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (obs !== 6'b101000) begin
        $display("FAIL timeout_on[%0d] got %b want %b", i, obs, 6'b101000); errors++;
      end
      step();
    end
    checks++;
    if (obs !== 6'b001010) begin
      $display("FAIL timeout_pulse_cycle got %b want %b", obs, 6'b001010); errors++;
    end
    step();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs !== 6'b001000) begin
        $display("FAIL timeout_hold[%0d] got %b want %b", i, obs, 6'b001000); errors++;
      end
      step();
    end
    checks++;
    if (obs !== 6'b000000) begin
      $display("FAIL timeout_idle got %b want %b", obs, 6'b000000); errors++;
    end
    step();
    checks++;
    if (obs !== 6'b101000) begin
      $display("FAIL timeout_restart got %b want %b", obs, 6'b101000); errors++;
    end
    hot = 1'b0;
    while (pump_busy && waited < 40) begin
      step(); waited++;
    end
    checks++;
    if (pump_busy !== 1'b0) begin
      $display("FAIL timeout_wind_down got busy=%b want 0", pump_busy); errors++;
    end
  endtask

  task automatic test_conflict();
    hot = 1'b1; cold = 1'b1;
    step();
    checks++;
    if (obs !== 6'b000001) begin
      $display("FAIL conflict_flag got %b want %b", obs, 6'b000001); errors++;
    end
    step();
    checks++;
    if (obs !== 6'b000001) begin
      $display("FAIL conflict_held got %b want %b", obs, 6'b000001); errors++;
    end
    hot = 1'b0; cold = 1'b0;
    step();
    checks++;
    if (obs !== 6'b000000) begin
      $display("FAIL conflict_clear got %b want %b", obs, 6'b000000); errors++;
    end
  endtask

  task automatic test_dryrun();
    cold = 1'b1;
    step();
    checks++;
    if (obs !== 6'b011000) begin
      $display("FAIL dry_cold_on got %b want %b", obs, 6'b011000); errors++;
    end
    lvl = 2'b00;
    step();
`ifdef PUMP_DRYRUN_EN
    checks++;
    if (obs !== 6'b000100) begin
      $display("FAIL dry_fault_entry got %b want %b", obs, 6'b000100); errors++;
    end
    lvl = 2'b11; hot = 1'b1; cold = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (obs !== 6'b000100) begin
      $display("FAIL dry_fault_sticky got %b want %b", obs, 6'b000100); errors++;
    end
    hot = 1'b0;
    rst = 1'b1;
    step();
    checks++;
    if (obs !== 6'b000000) begin
      $display("FAIL dry_fault_reset got %b want %b", obs, 6'b000000); errors++;
    end
    rst = 1'b0;
    step();
`else
    checks++;
    if (obs !== 6'b011000) begin
      $display("FAIL dry_ignored got %b want %b", obs, 6'b011000); errors++;
    end
    lvl = 2'b11; cold = 1'b0;
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (obs !== 6'b000000) begin
      $display("FAIL dry_ignored_end got %b want %b", obs, 6'b000000); errors++;
    end
`endif
  endtask

  task automatic test_reset_mid();
    hot = 1'b1;
    step(); step();
    checks++;
    if (obs !== 6'b101000) begin
      $display("FAIL mid_reset_on got %b want %b", obs, 6'b101000); errors++;
    end
    rst = 1'b1;
    step();
    checks++;
    if (obs !== 6'b000000) begin
      $display("FAIL mid_reset_off got %b want %b", obs, 6'b000000); errors++;
    end
    rst = 1'b0;
    step();
    checks++;
    if (obs !== 6'b101000) begin
      $display("FAIL mid_reset_relaunch got %b want %b", obs, 6'b101000); errors++;
    end
    hot = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hot_pulse();
    test_changeover();
    test_timeout();
    test_conflict();
    test_dryrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pump_driver.md
PUMP_DRIVER -- requirements
Module: pump_driver

Interface
REQ-001 Parameter CLK_DIV, default 50000000, clk cycles per tick; legal range 1 to 2^32-1.
REQ-002 Parameter MIN_ON_TICKS, default 10, minimum pump-on dwell in ticks; legal range 1 to 65535.
REQ-003 Parameter MIN_OFF_TICKS, default 5, minimum forced-off dwell in ticks; legal range 1 to 65535.
REQ-004 Parameter MAX_ON_TICKS, default 600, continuous-on limit in ticks; legal range MIN_ON_TICKS to 65535.
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 pump_control_hot  in  1  hot-pump request, synchronous to clk.
REQ-008 pump_control_cold  in  1  cold-pump request, synchronous to clk.
REQ-009 waterlvl_sensor  in  2  water level; 2'b00 means dry.
REQ-010 hot_pump_en  out  1  hot pump drive.
REQ-011 cold_pump_en  out  1  cold pump drive.
REQ-012 pump_busy  out  1  high in HOT_ON, COLD_ON or HOLD_OFF.
REQ-013 fault  out  1  high in FAULT.
REQ-014 timeout_pulse  out  1  one-cycle pulse on a MAX_ON_TICKS forced shutdown.
REQ-015 cmd_conflict  out  1  registered flag, high the cycle after both requests are sampled high.

Function
REQ-016 The prescaler shall count 0 to CLK_DIV-1 and assert an internal tick for one cycle at CLK_DIV-1; with CLK_DIV=1 the tick is asserted every cycle.
REQ-017 Qualified requests: req_hot = hot AND NOT cold; req_cold = cold AND NOT hot; both high shall count as no request.
REQ-018 The state machine shall have states IDLE, HOT_ON, COLD_ON, HOLD_OFF and FAULT, and all outputs except timeout_pulse and cmd_conflict shall be decoded from the state register.
REQ-019 hot_pump_en shall be high only in HOT_ON, and cold_pump_en shall be high only in COLD_ON; the two shall never be high together.
REQ-020 A 16-bit saturating dwell counter shall clear on every state entry and increment on each tick while the state is unchanged.
REQ-021 IDLE: req_hot goes to HOT_ON and req_cold goes to COLD_ON on the next edge, giving a request-to-drive latency of 1 cycle.
REQ-022 HOT_ON/COLD_ON: transition to HOLD_OFF when dwell >= MAX_ON_TICKS (timeout), else when dwell >= MIN_ON_TICKS and its own qualified request is low.
REQ-023 A request that drops before MIN_ON_TICKS shall not shorten the on period; with CLK_DIV=1 the minimum on period is MIN_ON_TICKS+1 cycles.
REQ-024 timeout_pulse shall be high for exactly the first cycle of HOLD_OFF entered by timeout.
REQ-025 HOLD_OFF: transition to IDLE when dwell >= MIN_OFF_TICKS, regardless of requests, so a hot-to-cold changeover always passes through HOLD_OFF and IDLE.
REQ-026 Priority in every state: fault condition > timeout > minimum-dwell rules > requests.
REQ-027 FAULT: both pumps off; the block shall leave FAULT only on rst.

Reset
REQ-028 rst high at a clock edge shall force IDLE, prescaler=0, dwell=0, and all outputs to 0 on that edge, including mid-HOT_ON/COLD_ON and in FAULT.

Configuration
REQ-029 Macro PUMP_DRYRUN_EN defined: waterlvl_sensor==2'b00 sampled in any state shall move the block to FAULT on the next edge.
REQ-030 PUMP_DRYRUN_EN undefined: the waterlvl_sensor port shall remain but be ignored, FAULT shall be unreachable, and fault shall be constant 0.

Verification
REQ-031 The bench shall use CLK_DIV=1, MIN_ON_TICKS=3, MIN_OFF_TICKS=2, MAX_ON_TICKS=8 for all scenarios below.
REQ-032 1-cycle hot pulse after reset -> hot_pump_en high for exactly 4 cycles starting 1 cycle later, then pump_busy high and pumps off for 3 cycles, then IDLE.
REQ-033 hot held, then cold-only requested after 6 cycles -> hot_pump_en falls, cold_pump_en rises exactly 4 cycles after the fall, and the two are never high together.
REQ-034 hot held continuously -> hot_pump_en high for 9 cycles, timeout_pulse high for 1 cycle as it falls, off for 3 cycles, IDLE for 1 cycle, then hot_pump_en high again.
REQ-035 hot=cold=1 in IDLE -> cmd_conflict=1 one cycle later and both pumps stay 0.
REQ-036 PUMP_DRYRUN_EN defined, waterlvl_sensor=2'b00 during COLD_ON -> next cycle cold_pump_en=0 and fault=1, held until rst, after which all outputs are 0.
